control_unit: RTL
=================

# control_unit

Hardwired Moore-style sequencer that drives every control input of the CPU datapath, one microstep per clock. It sits directly upstream of the datapath. It consumes the instruction register contents and the CON_FF branch flag, and issues register, bus, ALU, memory and I/O strobes to fetch, decode and execute one instruction at a time. It also owns the run/halt status of the processor.

## Interface

Parameters
- None. The opcode map is fixed: IR[31:27].
  - 00000 ld, 00001 ldi, 00010 st
  - 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or
  - 01011 addi, 01100 andi, 01101 ori
  - 01110 mul, 01111 div, 10000 neg, 10001 not
  - 10010 branch, 10011 jr, 10100 jal, 10101 in, 10110 out, 10111 mfhi, 11000 mflo, 11001 nop, 11010 halt

Ports
- clk  in  1  single system clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register from the datapath; only IR[31:27] is decoded.
- CON_FF  in  1  branch-condition flag from the datapath.
- stop  in  1  halt request, sampled only at instruction boundaries.
- run  out  1  1 while executing; 0 in HALT.
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout, Rout  out  1 each  bus source selects.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, OutPort, CONin  out  1 each  register load enables.
- Gra, Grb, Grc  out  1 each  register-field selects for the select/encode logic.
- read, write  out  1 each  memory strobes.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  out  1 each  ALU operation selects; at most one is high per cycle.

## Operation

- States: RST, T0–T7 (fetch/execute steps), HALT.
  - The state register holds the step; the decoded opcode is read combinationally from IR during T3–T7.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin.
  - T2: MDRout, IRin.
- Execute sequences. The last listed step returns to T0 on the next edge.
  - add/sub/shr/shl/ror/rol/and/or:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, op, Zin.
    - T5: Zlowout, Gra, Rin.
  - addi/andi/ori: same as above, but T4 uses Cout instead of Grc/Rout. andi→AND, ori→OR, addi→ADD.
  - neg/not:
    - T3: Grb, Rout, op, Zin.
    - T4: Zlowout, Gra, Rin.
  - mul/div:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, op, Zin.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - ldi:
    - T3: Grb, BAout, Yin.
    - T4: Cout, ADD, Zin.
    - T5: Zlowout, Gra, Rin.
  - ld:
    - T3–T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: read, MDRin.
    - T7: MDRout, Gra, Rin.
  - st:
    - T3–T5 as ld.
    - T6: Gra, Rout, MDRin, with read=0.
    - T7: write.
  - branch:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, ADD, Zin.
    - T6: Zlowout, PCin. In T6, PCin is gated by CON_FF; this is the only Mealy output. Zlowout is unconditional.
  - jr: T3: Gra, Rout, PCin.
  - jal (link register is the Rb field; the assembler encodes R15):
    - T3: PCout, Grb, Rin.
    - T4: Gra, Rout, PCin.
  - in: T3: Inportout, Gra, Rin.
  - out: T3: Gra, Rout, OutPort.
  - mfhi: T3: HIout, Gra, Rin.
  - mflo: T3: LOout, Gra, Rin.
  - nop, and any unlisted opcode: T3 asserts nothing, then T0.
  - halt: T3 → HALT.
- HALT: run=0, all other outputs 0. Held until reset; stop has no effect there.
- stop:
  - Sampled on the edge that would enter T0 (the last step of an instruction, or RST).
  - If stop=1, the next state is HALT instead of T0.
  - The in-flight instruction always completes.

## Timing

- Reset: clear=0 forces state=RST immediately, regardless of clk.
  - In RST, every output is 0 and run=1.
  - This applies mid-instruction too: any partial sequence is abandoned, and no write, read or Rin is asserted after clear falls.
- The first rising edge with clear=1 moves RST → T0 (or → HALT if stop=1).
- Outputs are combinational decodes of the current state plus IR[31:27] (plus CON_FF in branch T6). They are valid for the entire state cycle.
- Latency, counted in cycles from T0 entry to the next T0:
  - 6: reg-reg ALU, immediate ALU, ldi.
  - 5: neg, not, jal.
  - 7: mul, div, branch.
  - 8: ld, st.
  - 4: jr, in, out, mfhi, mflo, nop.
- IR is stable from T3 onward, because IRin is only high in T2.
- write is high for exactly one cycle (st T7). read is high only in T1 and ld T6. read and write are never high together.

## Test plan

- Reset, then IR=0x18000000 (add): exactly 6 cycles T0–T5. Check T4 has Grc=Rout=ADD=Zin=1, T5 has Gra=Rin=Zlowout=1, then T0 follows.
- ld (IR[31:27]=00000): 8 cycles; read high in T1 and T6 only; T7 has MDRout=Gra=Rin=1. st (00010): write=1 only in T7, with read=0 there.
- branch with CON_FF=1 in T6: PCin=1. Same instruction with CON_FF=0: PCin=0 and Zlowout=1; both return to T0 after 7 cycles.
- mul (01110): T5 LOin=1 with Zlowout=1, T6 HIin=1 with Zhighout=1; the MUL select is high only in T4.
- halt (11010): run falls on the cycle after T3 and stays 0 for ≥20 cycles. Separately, stop=1 raised during add T4: add completes T5, then HALT is entered with no T0.
- clear pulsed low asynchronously during st T6 (between edges): all outputs drop to 0 without waiting for clk, write is never asserted, and the first edge after release enters T0.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired microstep sequencer for the CPU datapath: fetch T0-T2, opcode-dependent execute T3-T7.
// Outputs decode the current step and IR[31:27]; only branch T6 PCin also looks at CON_FF.
//
// state | meaning
// RST   | held in reset, all strobes low, run=1
// T0-T2 | common fetch (PC->MAR, memory read, MDR->IR)
// T3-T7 | execute steps, length depends on opcode
// HALT  | stopped until reset, run=0
module control_unit (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Inportout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        OutPort,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        read,
  output logic        write,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd26;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] last_step;
  logic [4:0] op;
  logic       alu_go;
  logic       force_add;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  last_step = S_T5;
      OP_NEG, OP_NOT, OP_JAL:            last_step = S_T4;
      OP_MUL, OP_DIV, OP_BR:             last_step = S_T6;
      OP_LD, OP_ST:                      last_step = S_T7;
      default:                           last_step = S_T3;
    endcase
  end

  // stop is only looked at on the edge that would otherwise enter T0
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = stop ? S_HALT : S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state == last_step)
          state_nxt = (op == OP_HALT || stop) ? S_HALT : S_T0;
        else
          state_nxt = state + 4'd1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear)
      state <= S_RST;
    else
      state <= state_nxt;
  end

  always_comb begin
    run       = (state != S_HALT);
    PCout     = 1'b0;
    MDRout    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    Inportout = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Rin       = 1'b0;
    OutPort   = 1'b0;
    CONin     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    IncPC     = 1'b0;
    alu_go    = 1'b0;
    force_add = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI:
                   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_NEG, OP_NOT:
                   begin Grb = 1'b1; Rout = 1'b1; alu_go = 1'b1; Zin = 1'b1; end
          OP_MUL, OP_DIV:
                   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_LDI, OP_LD, OP_ST:
                   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          OP_IN:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
                   begin Grc = 1'b1; Rout = 1'b1; alu_go = 1'b1; Zin = 1'b1; end
          OP_ADDI, OP_ANDI, OP_ORI:
                   begin Cout = 1'b1; alu_go = 1'b1; Zin = 1'b1; end
          OP_NEG, OP_NOT:
                   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV:
                   begin Grb = 1'b1; Rout = 1'b1; alu_go = 1'b1; Zin = 1'b1; end
          OP_LDI, OP_LD, OP_ST:
                   begin Cout = 1'b1; force_add = 1'b1; Zin = 1'b1; end
          OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV:
                   begin Zlowout = 1'b1; LOin = 1'b1; end
          OP_LD, OP_ST:
                   begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_BR:   begin Cout = 1'b1; force_add = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          OP_LD:   begin read = 1'b1; MDRin = 1'b1; end
          OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // branch target is only committed when the condition holds
          OP_BR:   begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ADD = force_add | (alu_go & (op == OP_ADD || op == OP_ADDI));
  assign AND = alu_go & (op == OP_AND || op == OP_ANDI);
  assign OR  = alu_go & (op == OP_OR || op == OP_ORI);
  assign SUB = alu_go & (op == OP_SUB);
  assign SHR = alu_go & (op == OP_SHR);
  assign SHL = alu_go & (op == OP_SHL);
  assign ROR = alu_go & (op == OP_ROR);
  assign ROL = alu_go & (op == OP_ROL);
  assign MUL = alu_go & (op == OP_MUL);
  assign DIV = alu_go & (op == OP_DIV);
  assign NEG = alu_go & (op == OP_NEG);
  assign NOT = alu_go & (op == OP_NOT);

endmodule
